// File: rtl/mmu_addr_trans_if.sv
// Request/response handshake bundle between a pipeline stage and the translation stage.
interface mmu_addr_trans_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [1:0]  req_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_paddr;
    logic [1:0]  resp_mat;
    logic [2:0]  resp_exc;

    modport master (
        output req_valid, req_vaddr, req_type, resp_ready,
        input  req_ready, resp_valid, resp_paddr, resp_mat, resp_exc
    );

    modport slave (
        input  req_valid, req_vaddr, req_type, resp_ready,
        output req_ready, resp_valid, resp_paddr, resp_mat, resp_exc
    );
endinterface

// File: rtl/mmu_addr_trans.sv
// Virtual-to-physical translation stage: DA / DMW resolve in one cycle, TLB-mapped
// accesses search the TLB in the accept cycle and register its result one cycle later.
module mmu_addr_trans #(
    parameter int HUGE_PS = 21
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    mmu_addr_trans_if.slave bus,
    input  logic        csr_da,
    input  logic        csr_pg,
    input  logic [1:0]  csr_plv,
    input  logic [1:0]  csr_datf,
    input  logic [1:0]  csr_datm,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1,
    input  logic [9:0]  csr_asid,
    output logic        tlb_fetch,
    output logic [18:0] tlb_vppn,
    output logic        tlb_odd_page,
    output logic [9:0]  tlb_asid,
    input  logic        tlb_found,
    input  logic [5:0]  tlb_ps,
    input  logic [19:0] tlb_ppn,
    input  logic        tlb_v,
    input  logic        tlb_d,
    input  logic [1:0]  tlb_mat,
    input  logic [1:0]  tlb_plv
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    localparam logic [2:0] EXC_NONE = 3'd0, EXC_TLBR = 3'd1, EXC_PIL = 3'd2, EXC_PIS = 3'd3,
                           EXC_PIF  = 3'd4, EXC_PME  = 3'd5, EXC_PPI = 3'd6;

    state_t      state_q;
    logic        resp_valid_q;
    logic [31:0] resp_paddr_q;
    logic [1:0]  resp_mat_q;
    logic [2:0]  resp_exc_q;
    logic [1:0]  type_q;
    logic [20:0] voff_q;
    logic [1:0]  plv_q;

    logic        accept;
    logic        dmw0_hit, dmw1_hit, tlb_mode;
    logic [31:0] direct_paddr_d;
    logic [1:0]  direct_mat_d;
    logic [31:0] lookup_paddr_d;
    logic [2:0]  lookup_exc_d;
    logic        huge_page;
    logic        unused_xor;

    assign bus.req_ready = !flush && ((state_q == IDLE) || (state_q == RESP && bus.resp_ready));
    assign accept        = bus.req_valid && bus.req_ready;

    assign tlb_vppn      = bus.req_vaddr[31:13];
    assign tlb_odd_page  = bus.req_vaddr[12];
    assign tlb_asid      = csr_asid;
    assign tlb_fetch     = accept && tlb_mode;

    // Windows only match for PLV0 (bit 0) or PLV3 (bit 3); PLV1/2 never hit a DMW.
    function automatic logic dmw_match(input logic [31:0] dmw, input logic [1:0] plv,
                                       input logic [2:0] vseg);
        logic plv_ok;
        plv_ok = (plv == 2'd0) ? dmw[0] : (plv == 2'd3) ? dmw[3] : 1'b0;
        return plv_ok && (dmw[31:29] == vseg);
    endfunction

    assign dmw0_hit  = dmw_match(csr_dmw0, csr_plv, bus.req_vaddr[31:29]);
    assign dmw1_hit  = dmw_match(csr_dmw1, csr_plv, bus.req_vaddr[31:29]);
    assign tlb_mode  = !csr_da && !dmw0_hit && !dmw1_hit;
    assign huge_page = (tlb_ps == HUGE_PS[5:0]) || (tlb_ps != 6'd12);

    always_comb begin
        direct_paddr_d = bus.req_vaddr;
        direct_mat_d   = (bus.req_type == 2'd0) ? csr_datf : csr_datm;
        if (!csr_da && dmw0_hit) begin
            direct_paddr_d = {csr_dmw0[27:25], bus.req_vaddr[28:0]};
            direct_mat_d   = csr_dmw0[5:4];
        end else if (!csr_da && dmw1_hit) begin
            direct_paddr_d = {csr_dmw1[27:25], bus.req_vaddr[28:0]};
            direct_mat_d   = csr_dmw1[5:4];
        end
    end

    always_comb begin
        lookup_paddr_d = huge_page ? {tlb_ppn[19:9], voff_q} : {tlb_ppn, voff_q[11:0]};
        lookup_exc_d   = EXC_NONE;
        if (!tlb_found)
            lookup_exc_d = EXC_TLBR;
        else if (!tlb_v)
            lookup_exc_d = (type_q == 2'd0) ? EXC_PIF : (type_q == 2'd2) ? EXC_PIS : EXC_PIL;
        else if (plv_q > tlb_plv)
            lookup_exc_d = EXC_PPI;
        else if (type_q == 2'd2 && !tlb_d)
            lookup_exc_d = EXC_PME;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_mat_q   <= '0;
            resp_exc_q   <= '0;
            type_q       <= '0;
            voff_q       <= '0;
            plv_q        <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
        end else if (accept) begin
            if (tlb_mode) begin
                state_q      <= LOOKUP;
                resp_valid_q <= 1'b0;
                type_q       <= bus.req_type;
                voff_q       <= bus.req_vaddr[20:0];
                plv_q        <= csr_plv;
            end else begin
                state_q      <= RESP;
                resp_valid_q <= 1'b1;
                resp_paddr_q <= direct_paddr_d;
                resp_mat_q   <= direct_mat_d;
                resp_exc_q   <= EXC_NONE;
            end
        end else begin
            case (state_q)
                LOOKUP: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_paddr_q <= lookup_paddr_d;
                    resp_mat_q   <= tlb_mat;
                    resp_exc_q   <= lookup_exc_d;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_paddr = resp_paddr_q;
    assign bus.resp_mat   = resp_mat_q;
    assign bus.resp_exc   = resp_exc_q;

    // Paging-enable and the unused CSR/PPN bits do not influence translation here.
    assign unused_xor = ^{csr_pg, csr_dmw0, csr_dmw1, tlb_ppn, bus.req_vaddr};
endmodule
